// File: rtl/cacheline_adapter.sv
// Purpose: bridges 256-bit cache line fills and writebacks to a 4 x 64-bit burst memory.
// Latency: write beats start 1 cycle after request; dfp_resp 1 cycle after the last beat.
// Backpressure: bmem_ready stalls the read command and write beats; read beats arrive on bmem_rvalid.
module cacheline_adapter (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  dfp_addr,
  input  logic         dfp_read,
  input  logic         dfp_write,
  input  logic [255:0] dfp_wdata,
  output logic [255:0] dfp_rdata,
  output logic         dfp_resp,
  output logic [31:0]  bmem_addr,
  output logic         bmem_read,
  output logic         bmem_write,
  output logic [63:0]  bmem_wdata,
  input  logic         bmem_ready,
  input  logic [63:0]  bmem_rdata,
  input  logic         bmem_rvalid
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_CMD   = 3'd1;
  localparam logic [2:0] RD_BEATS = 3'd2;
  localparam logic [2:0] WR_BEATS = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]   state_q, state_d;
  logic [1:0]   beat_q, beat_d;
  logic [31:0]  addr_q, addr_d;
  logic [255:0] wdata_q, wdata_d;
  logic [255:0] rdata_q, rdata_d;

  // Next-state: capture the request in IDLE, then walk the burst using only latched values.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        // Write wins when both requests are raised together.
        if (dfp_write || dfp_read) begin
          addr_d  = dfp_addr & 32'hFFFF_FFE0;
          wdata_d = dfp_wdata;
          beat_d  = 2'd0;
          state_d = dfp_write ? WR_BEATS : RD_CMD;
        end
      end
      RD_CMD: begin
        if (bmem_ready) begin
          state_d = RD_BEATS;
        end
      end
      RD_BEATS: begin
        if (bmem_rvalid) begin
          rdata_d[{beat_q, 6'd0} +: 64] = bmem_rdata;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d = DONE;
          end
        end
      end
      WR_BEATS: begin
        // Beat index only moves on an accepted beat, so a stall neither skips nor repeats.
        if (bmem_ready) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from state; everything is quiet outside the active burst states.
  always_comb begin
    dfp_resp   = 1'b0;
    bmem_addr  = 32'd0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = 64'd0;
    case (state_q)
      RD_CMD: begin
        bmem_read = 1'b1;
        bmem_addr = addr_q;
      end
      WR_BEATS: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = wdata_q[{beat_q, 6'd0} +: 64];
      end
      DONE: begin
        dfp_resp = 1'b1;
      end
      default: begin
        dfp_resp = 1'b0;
      end
    endcase
  end

  assign dfp_rdata = rdata_q;

  // State registers with synchronous reset that abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 256'd0;
      rdata_q <= 256'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Purpose: directed self-checking bench for cacheline_adapter.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: bmem_ready/bmem_rvalid are driven directly by the step sequence.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [63:0] WA = 64'hAAAA_AAAA_0000_000A;
  localparam logic [63:0] WB = 64'hBBBB_BBBB_0000_000B;
  localparam logic [63:0] WC = 64'hCCCC_CCCC_0000_000C;
  localparam logic [63:0] WD = 64'hDDDD_DDDD_0000_000D;
  localparam logic [63:0] R1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] R2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] R3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] R4 = 64'h4444_4444_4444_4444;

  logic [255:0] line_exp;
  logic [63:0]  beats [4];

  cacheline_adapter dut (
    .clk         (clk),
    .rst         (rst),
    .dfp_addr    (dfp_addr),
    .dfp_read    (dfp_read),
    .dfp_write   (dfp_write),
    .dfp_wdata   (dfp_wdata),
    .dfp_rdata   (dfp_rdata),
    .dfp_resp    (dfp_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; dfp_addr = 32'd0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = 256'd0;
    bmem_ready = 1'b0; bmem_rdata = 64'd0; bmem_rvalid = 1'b0;
    beats[0] = R1; beats[1] = R2; beats[2] = R3; beats[3] = R4;
    tick(); tick();
    chk("rst_resp", dfp_resp, 0);
    chk("rst_bread", bmem_read, 0);
    chk("rst_bwrite", bmem_write, 0);
    chk("rst_baddr", bmem_addr, 0);
    chk("rst_bwdata", bmem_wdata, 0);
    chk("rst_rdata", dfp_rdata, 0);
    rst = 1'b0;

    // Read of 0x1234 with a 3-cycle gap before the beats.
    dfp_addr = 32'h0000_1234; dfp_read = 1'b1; bmem_ready = 1'b1;
    tick();
    dfp_read = 1'b0; dfp_addr = 32'hFFFF_FFFF;
    chk("rd_cmd", bmem_read, 1);
    chk("rd_addr", bmem_addr, 32'h0000_1220);
    chk("rd_nowrite", bmem_write, 0);
    bmem_rvalid = 1'b1; bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    bmem_rvalid = 1'b0;
    chk("rd_single_cmd", bmem_read, 0);
    chk("rd_stray_ignored", dfp_rdata, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd_gap_resp", dfp_resp, 0);
    end
    for (int i = 0; i < 4; i++) begin
      bmem_rvalid = 1'b1; bmem_rdata = beats[i];
      tick();
      bmem_rvalid = 1'b0;
      chk("rd_beat_resp", dfp_resp, (i == 3) ? 1 : 0);
    end
    line_exp = {R4, R3, R2, R1};
    chk("rd_line", dfp_rdata, line_exp);
    tick();
    chk("rd_resp_one_cycle", dfp_resp, 0);
    chk("rd_line_hold", dfp_rdata, line_exp);

    // Write of 0x8000_0040 with full-speed acceptance; cache inputs scrambled mid-burst.
    dfp_addr = 32'h8000_0040; dfp_write = 1'b1; dfp_wdata = {WD, WC, WB, WA}; bmem_ready = 1'b1;
    tick();
    dfp_write = 1'b0; dfp_wdata = {4{64'h5555_5555_5555_5555}}; dfp_addr = 32'h0;
    chk("wr_b0", bmem_wdata, WA);
    chk("wr_addr", bmem_addr, 32'h8000_0040);
    chk("wr_valid", bmem_write, 1);
    chk("wr_noread", bmem_read, 0);
    tick(); chk("wr_b1", bmem_wdata, WB);
    tick(); chk("wr_b2", bmem_wdata, WC);
    tick(); chk("wr_b3", bmem_wdata, WD);
    chk("wr_addr_b3", bmem_addr, 32'h8000_0040);
    tick();
    chk("wr_resp", dfp_resp, 1);
    chk("wr_done_idle", bmem_write, 0);
    chk("wr_rdata_kept", dfp_rdata, line_exp);
    tick();
    chk("wr_resp_one_cycle", dfp_resp, 0);

    // Write with beat B stalled for 3 cycles.
    dfp_addr = 32'h8000_0040; dfp_write = 1'b1; dfp_wdata = {WD, WC, WB, WA}; bmem_ready = 1'b1;
    tick();
    dfp_write = 1'b0;
    chk("st_b0", bmem_wdata, WA);
    tick();
    for (int i = 0; i < 4; i++) begin
      bmem_ready = (i == 3);
      chk("st_b1_held", bmem_wdata, WB);
      chk("st_resp_low", dfp_resp, 0);
      tick();
    end
    chk("st_b2", bmem_wdata, WC);
    tick(); chk("st_b3", bmem_wdata, WD);
    tick(); chk("st_resp", dfp_resp, 1);
    tick();

    // Read and write together: only the write burst is issued.
    dfp_addr = 32'h0000_0100; dfp_read = 1'b1; dfp_write = 1'b1; dfp_wdata = {WA, WB, WC, WD};
    tick();
    dfp_read = 1'b0; dfp_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("both_write", bmem_write, 1);
      chk("both_noread", bmem_read, 0);
      tick();
    end
    chk("both_resp", dfp_resp, 1);
    chk("both_rdata_kept", dfp_rdata, line_exp);
    tick();

    // Reset after read beat 2, then stray beats.
    dfp_addr = 32'h0000_0040; dfp_read = 1'b1;
    tick();
    dfp_read = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      bmem_rvalid = 1'b1; bmem_rdata = beats[i];
      tick();
    end
    bmem_rvalid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_rdata_clr", dfp_rdata, 0);
    for (int i = 0; i < 3; i++) begin
      bmem_rvalid = 1'b1; bmem_rdata = beats[i + 1];
      tick();
      chk("rr_no_resp", dfp_resp, 0);
      chk("rr_rdata_zero", dfp_rdata, 0);
      chk("rr_idle_read", bmem_read, 0);
      chk("rr_idle_write", bmem_write, 0);
    end
    bmem_rvalid = 1'b0;

    // dfp_read held through completion: one IDLE cycle before the next read.
    dfp_addr = 32'h0000_2000; dfp_read = 1'b1;
    tick(); chk("hold_cmd", bmem_read, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      bmem_rvalid = 1'b1; bmem_rdata = beats[3 - i];
      tick();
    end
    bmem_rvalid = 1'b0;
    chk("hold_resp", dfp_resp, 1);
    chk("hold_line", dfp_rdata, {R1, R2, R3, R4});
    tick();
    chk("hold_idle_resp", dfp_resp, 0);
    chk("hold_idle_read", bmem_read, 0);
    tick();
    dfp_read = 1'b0;
    chk("hold_second_cmd", bmem_read, 1);
    chk("hold_second_addr", bmem_addr, 32'h0000_2000);
    chk("hold_second_noresp", dfp_resp, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
